alu_writeback_stage: RTL and testbench
======================================

Name: alu_writeback_stage

Overview:
- Sits directly downstream of the 32-bit ALU. Consumes its result bus R1 plus the N/Z/V/C flags and the 4-bit optcode.
- Holds the architectural flag register NZVC. Flags are updated selectively per optcode.
- Forwards register-writeback beats to the register file through a 2-entry skid buffer with a valid/ready handshake.
- Evaluates a 4-bit branch condition against the stored flags. Counts illegal optcodes.

Parameters:
- DATA_W, 32, width of the result and writeback data
- ADDR_W, 5, width of the destination register index
- CNT_W, 8, width of the saturating illegal-op counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ALU beat valid
- in_ready  output  1  stage can accept a beat; registered (equals NOT skid_valid)
- in_result  input  DATA_W  ALU R1
- in_negative  input  1  ALU N flag
- in_zero  input  1  ALU Z flag
- in_overflow  input  1  ALU V flag
- in_carry  input  1  ALU C flag
- in_optcode  input  4  optcode that produced the beat
- in_dest  input  ADDR_W  destination register index
- wb_valid  output  1  writeback beat valid
- wb_ready  input  1  register file accepts the beat
- wb_data  output  DATA_W  writeback data
- wb_addr  output  ADDR_W  writeback register index
- flags  output  4  stored {N,Z,V,C}
- cond_sel  input  4  condition to evaluate
- cond_true  output  1  combinational result of cond_sel applied to flags
- illegal_cnt  output  CNT_W  saturating count of illegal optcodes accepted

Behaviour:
- Reset, synchronous: flags=0000, wb_valid=0, wb_data=0, wb_addr=0, skid buffer emptied, in_ready=1 on the next cycle, illegal_cnt=0.
- Reset mid-operation discards any buffered beats. Flag updates pending in the same cycle are also discarded; reset wins.
- Accept condition: in_valid & in_ready. Nothing is sampled otherwise.
- Flag update on accept, visible the cycle after accept:
  - optcode 0000/0001/0010/1001 (ADD/SUB/MUL/CMP): update N, Z, V, C.
  - 0110/0111/1000 (SHR/SHL/ROR): update N, Z, C; hold V.
  - 0011/0100/0101 (OR/AND/XOR): update N, Z; hold V, C.
  - 1010–1111: illegal. No flag change; illegal_cnt += 1, saturating at all-ones.
- Writeback classes:
  - Optcodes 0000–1000 produce a writeback beat {in_result, in_dest}.
  - 1001 (CMP) and illegal optcodes consume the handshake but produce no beat.
- Skid buffer: output register (wb_*) plus one skid register.
  - An accepted beat goes to the output register if that register is empty or draining this cycle (wb_valid & wb_ready) and skid is empty.
  - Otherwise the beat goes to skid.
  - When the output register drains and skid is full, skid moves to output that cycle and skid empties.
  - Order is strictly preserved.
  - Latency: accept in cycle t gives wb_valid in cycle t+1 when unstalled.
- in_ready = NOT skid_valid, registered. Throughput is 1 beat/cycle with wb_ready held high.
- wb_data and wb_addr are stable while wb_valid=1 and wb_ready=0.
- cond_sel encoding (applied to the registered flags):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0
- Simultaneous events: a beat accepted in cycle t updates flags in t+1, so cond_true in cycle t reflects the old flags. No bypass.
- Flag updates are independent of wb_ready. A stalled writeback never delays the flag update of an accepted beat.

Test Plan:
- Reset, then ADD beat (result 0x00000000, Z=1, C=1, dest 3) with wb_ready=1 -> wb_valid=1 next cycle, wb_addr=3, wb_data=0; flags=0101; cond_sel=0 gives cond_true=1.
- With flags=1111, OR beat with result 0x00000001 (N=0, Z=0) -> flags=0011 (V, C held); ROR beat with C=0, V=1 -> V still held, C cleared.
- CMP beat (optcode 1001, N=1, V=0) -> no wb_valid; flags N=1, V=0; cond_sel=B (LT) gives 1.
- wb_ready=0, three back-to-back ADD beats to dest 1, 2, 3 -> beats 1 and 2 buffered, in_ready=0 after the second accept, beat 3 held upstream. Raising wb_ready drains 1, 2, 3 in order with no loss or duplication.
- 260 illegal beats (optcode 1111) -> illegal_cnt saturates at 255, flags unchanged, no writeback.
- Assert reset while skid is full and wb_ready=0 -> next cycle wb_valid=0, in_ready=1, flags=0000.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: architectural NZVC flag register, a two-entry skid buffer
// toward the register file, branch-condition evaluation and an illegal-optcode counter.
module alu_writeback_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_negative,
    input  logic              in_zero,
    input  logic              in_overflow,
    input  logic              in_carry,
    input  logic [3:0]        in_optcode,
    input  logic [ADDR_W-1:0] in_dest,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [3:0]        flags,
    input  logic [3:0]        cond_sel,
    output logic              cond_true,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef enum logic [1:0] {
        CLS_NZVC = 2'd0,
        CLS_NZC  = 2'd1,
        CLS_NZ   = 2'd2,
        CLS_ILL  = 2'd3
    } flag_cls_t;

    // Which flags an optcode is allowed to touch.
    function automatic flag_cls_t decode_cls(input logic [3:0] op);
        flag_cls_t cls;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h9: cls = CLS_NZVC;
            4'h6, 4'h7, 4'h8:       cls = CLS_NZC;
            4'h3, 4'h4, 4'h5:       cls = CLS_NZ;
            default:                cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    function automatic logic [3:0] update_mask(input flag_cls_t cls);
        logic [3:0] m;
        case (cls)
            CLS_NZVC: m = 4'b1111;
            CLS_NZC:  m = 4'b1101;
            CLS_NZ:   m = 4'b1100;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

    // Condition codes over {N,Z,V,C}.
    function automatic logic eval_cond(input logic [3:0] sel, input logic [3:0] f);
        logic n, z, v, c, r;
        n = f[3];
        z = f[2];
        v = f[1];
        c = f[0];
        case (sel)
            4'h0:    r = z;
            4'h1:    r = ~z;
            4'h2:    r = c;
            4'h3:    r = ~c;
            4'h4:    r = n;
            4'h5:    r = ~n;
            4'h6:    r = v;
            4'h7:    r = ~v;
            4'h8:    r = c & ~z;
            4'h9:    r = ~c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = ~z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic              in_ready_r;
    logic [3:0]        flags_r;
    logic [CNT_W-1:0]  illegal_cnt_r;
    logic              wb_valid_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [ADDR_W-1:0] wb_addr_r;
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [ADDR_W-1:0] skid_addr_r;

    logic              accept_s;
    logic              push_s;
    logic              out_free_s;
    flag_cls_t         cls_s;
    logic [3:0]        mask_s;
    logic [3:0]        flags_in_s;
    logic [3:0]        flags_next_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              wb_valid_next_s;
    logic [DATA_W-1:0] wb_data_next_s;
    logic [ADDR_W-1:0] wb_addr_next_s;
    logic              skid_valid_next_s;
    logic [DATA_W-1:0] skid_data_next_s;
    logic [ADDR_W-1:0] skid_addr_next_s;

    assign accept_s   = in_valid & in_ready_r;
    assign cls_s      = decode_cls(in_optcode);
    assign mask_s     = update_mask(cls_s);
    assign flags_in_s = {in_negative, in_zero, in_overflow, in_carry};
    // CMP (0x9) and illegal optcodes consume the handshake without a writeback beat.
    assign push_s     = accept_s & (in_optcode <= 4'h8);
    assign out_free_s = ~wb_valid_r | wb_ready;

    // Next flag register value and saturating illegal counter.
    always_comb begin
        flags_next_s = flags_r;
        cnt_next_s   = illegal_cnt_r;
        if (accept_s) begin
            flags_next_s = (flags_r & ~mask_s) | (flags_in_s & mask_s);
            if ((cls_s == CLS_ILL) && (illegal_cnt_r != {CNT_W{1'b1}})) begin
                cnt_next_s = illegal_cnt_r + CNT_W'(1);
            end else begin
                cnt_next_s = illegal_cnt_r;
            end
        end else begin
            flags_next_s = flags_r;
        end
    end

    // Skid buffer next state; skid is always empty when a beat is accepted.
    always_comb begin
        wb_valid_next_s   = wb_valid_r;
        wb_data_next_s    = wb_data_r;
        wb_addr_next_s    = wb_addr_r;
        skid_valid_next_s = skid_valid_r;
        skid_data_next_s  = skid_data_r;
        skid_addr_next_s  = skid_addr_r;
        if (out_free_s) begin
            if (skid_valid_r) begin
                wb_valid_next_s = 1'b1;
                wb_data_next_s  = skid_data_r;
                wb_addr_next_s  = skid_addr_r;
                if (push_s) begin
                    skid_valid_next_s = 1'b1;
                    skid_data_next_s  = in_result;
                    skid_addr_next_s  = in_dest;
                end else begin
                    skid_valid_next_s = 1'b0;
                end
            end else if (push_s) begin
                wb_valid_next_s = 1'b1;
                wb_data_next_s  = in_result;
                wb_addr_next_s  = in_dest;
            end else begin
                wb_valid_next_s = 1'b0;
            end
        end else if (push_s) begin
            skid_valid_next_s = 1'b1;
            skid_data_next_s  = in_result;
            skid_addr_next_s  = in_dest;
        end else begin
            skid_valid_next_s = skid_valid_r;
        end
    end

    // State registers; reset discards buffered beats and same-cycle flag updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r    <= 1'b1;
            flags_r       <= 4'b0000;
            illegal_cnt_r <= {CNT_W{1'b0}};
            wb_valid_r    <= 1'b0;
            wb_data_r     <= {DATA_W{1'b0}};
            wb_addr_r     <= {ADDR_W{1'b0}};
            skid_valid_r  <= 1'b0;
            skid_data_r   <= {DATA_W{1'b0}};
            skid_addr_r   <= {ADDR_W{1'b0}};
        end else begin
            in_ready_r    <= ~skid_valid_next_s;
            flags_r       <= flags_next_s;
            illegal_cnt_r <= cnt_next_s;
            wb_valid_r    <= wb_valid_next_s;
            wb_data_r     <= wb_data_next_s;
            wb_addr_r     <= wb_addr_next_s;
            skid_valid_r  <= skid_valid_next_s;
            skid_data_r   <= skid_data_next_s;
            skid_addr_r   <= skid_addr_next_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign flags       = flags_r;
    assign illegal_cnt = illegal_cnt_r;
    assign wb_valid    = wb_valid_r;
    assign wb_data     = wb_data_r;
    assign wb_addr     = wb_addr_r;
    assign cond_true   = eval_cond(cond_sel, flags_r);

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed testbench for alu_writeback_stage with hand-computed expectations.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_negative, in_zero, in_overflow, in_carry;
    logic [3:0]  in_optcode;
    logic [4:0]  in_dest;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic [3:0]  flags;
    logic [3:0]  cond_sel;
    logic        cond_true;
    logic [7:0]  illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    alu_writeback_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_negative(in_negative), .in_zero(in_zero), .in_overflow(in_overflow),
        .in_carry(in_carry), .in_optcode(in_optcode), .in_dest(in_dest),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
        .flags(flags), .cond_sel(cond_sel), .cond_true(cond_true), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [3:0] op, input logic [31:0] res,
                            input logic [3:0] nzvc, input logic [4:0] dest);
        in_valid    = 1'b1;
        in_optcode  = op;
        in_result   = res;
        {in_negative, in_zero, in_overflow, in_carry} = nzvc;
        in_dest     = dest;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; wb_ready = 1'b1; cond_sel = 4'h0;
        set_beat(4'h0, 32'h0, 4'b0000, 5'd0);
        in_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (flags !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", flags); end
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", illegal_cnt); end
        n_cmp++; if (wb_data !== 32'h0 || wb_addr !== 5'd0) begin n_bad++; $display("FAIL reset_wb_bus got %h/%0d want 0/0", wb_data, wb_addr); end
    endtask

    task automatic test_add();
        wb_ready = 1'b1;
        set_beat(4'h0, 32'h0000_0000, 4'b0101, 5'd3);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL add_wb_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_addr !== 5'd3) begin n_bad++; $display("FAIL add_wb_addr got %0d want 3", wb_addr); end
        n_cmp++; if (wb_data !== 32'h0) begin n_bad++; $display("FAIL add_wb_data got %h want 0", wb_data); end
        n_cmp++; if (flags !== 4'b0101) begin n_bad++; $display("FAIL add_flags got %b want 0101", flags); end
        cond_sel = 4'h0; #1;
        n_cmp++; if (cond_true !== 1'b1) begin n_bad++; $display("FAIL add_cond_eq got %b want 1", cond_true); end
        cond_sel = 4'h8; #1;
        n_cmp++; if (cond_true !== 1'b0) begin n_bad++; $display("FAIL add_cond_hi got %b want 0", cond_true); end
        cond_sel = 4'h9; #1;
        n_cmp++; if (cond_true !== 1'b1) begin n_bad++; $display("FAIL add_cond_ls got %b want 1", cond_true); end
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL add_drained got %b want 0", wb_valid); end
    endtask

    task automatic test_partial_flags();
        wb_ready = 1'b1;
        set_beat(4'h1, 32'hFFFF_FFFF, 4'b1111, 5'd0);
        tick();
        n_cmp++; if (flags !== 4'b1111) begin n_bad++; $display("FAIL sub_flags got %b want 1111", flags); end
        set_beat(4'h3, 32'h0000_0001, 4'b0000, 5'd4);
        tick();
        n_cmp++; if (flags !== 4'b0011) begin n_bad++; $display("FAIL or_flags got %b want 0011", flags); end
        n_cmp++; if (wb_data !== 32'h1 || wb_addr !== 5'd4) begin n_bad++; $display("FAIL or_wb got %h/%0d want 1/4", wb_data, wb_addr); end
        set_beat(4'h8, 32'h0000_0002, 4'b0010, 5'd5);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (flags !== 4'b0010) begin n_bad++; $display("FAIL ror_flags got %b want 0010", flags); end
        cond_sel = 4'h6; #1;
        n_cmp++; if (cond_true !== 1'b1) begin n_bad++; $display("FAIL ror_cond_vs got %b want 1", cond_true); end
        cond_sel = 4'hA; #1;
        n_cmp++; if (cond_true !== 1'b0) begin n_bad++; $display("FAIL ror_cond_ge got %b want 0", cond_true); end
    endtask

    task automatic test_cmp();
        wb_ready = 1'b1;
        set_beat(4'h9, 32'h8000_0000, 4'b1000, 5'd7);
        cond_sel = 4'h4; #1;
        n_cmp++; if (cond_true !== 1'b0) begin n_bad++; $display("FAIL cmp_no_bypass got %b want 0", cond_true); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL cmp_no_wb got %b want 0", wb_valid); end
        n_cmp++; if (flags !== 4'b1000) begin n_bad++; $display("FAIL cmp_flags got %b want 1000", flags); end
        cond_sel = 4'hB; #1;
        n_cmp++; if (cond_true !== 1'b1) begin n_bad++; $display("FAIL cmp_cond_lt got %b want 1", cond_true); end
        cond_sel = 4'hD; #1;
        n_cmp++; if (cond_true !== 1'b1) begin n_bad++; $display("FAIL cmp_cond_le got %b want 1", cond_true); end
        cond_sel = 4'hF; #1;
        n_cmp++; if (cond_true !== 1'b0) begin n_bad++; $display("FAIL cmp_cond_nv got %b want 0", cond_true); end
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b0;
        set_beat(4'h0, 32'h0000_0011, 4'b0001, 5'd1);
        tick();
        n_cmp++; if (flags !== 4'b0001) begin n_bad++; $display("FAIL b2b_flags1 got %b want 0001", flags); end
        set_beat(4'h0, 32'h0000_0022, 4'b1000, 5'd2);
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
        n_cmp++; if (flags !== 4'b1000) begin n_bad++; $display("FAIL b2b_flags_stalled got %b want 1000", flags); end
        set_beat(4'h0, 32'h0000_0033, 4'b0100, 5'd3);
        tick();
        n_cmp++; if (wb_valid !== 1'b1 || wb_addr !== 5'd1 || wb_data !== 32'h11) begin n_bad++; $display("FAIL b2b_hold got %b/%0d/%h want 1/1/11", wb_valid, wb_addr, wb_data); end
        n_cmp++; if (flags !== 4'b1000) begin n_bad++; $display("FAIL b2b_beat3_not_taken got %b want 1000", flags); end
        wb_ready = 1'b1;
        tick();
        n_cmp++; if (wb_valid !== 1'b1 || wb_addr !== 5'd2 || wb_data !== 32'h22) begin n_bad++; $display("FAIL b2b_drain2 got %b/%0d/%h want 1/2/22", wb_valid, wb_addr, wb_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_again got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (wb_valid !== 1'b1 || wb_addr !== 5'd3 || wb_data !== 32'h33) begin n_bad++; $display("FAIL b2b_drain3 got %b/%0d/%h want 1/3/33", wb_valid, wb_addr, wb_data); end
        n_cmp++; if (flags !== 4'b0100) begin n_bad++; $display("FAIL b2b_flags3 got %b want 0100", flags); end
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %b want 0", wb_valid); end
    endtask

    task automatic test_illegal();
        int wb_seen = 0;
        wb_ready = 1'b1;
        set_beat(4'hF, 32'hDEAD_BEEF, 4'b1011, 5'd9);
        for (int i = 0; i < 260; i++) begin
            tick();
            if (wb_valid === 1'b1) wb_seen++;
            if (i == 9) begin
                n_cmp++; if (illegal_cnt !== 8'd10) begin n_bad++; $display("FAIL ill_cnt10 got %0d want 10", illegal_cnt); end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (illegal_cnt !== 8'd255) begin n_bad++; $display("FAIL ill_saturate got %0d want 255", illegal_cnt); end
        n_cmp++; if (flags !== 4'b0100) begin n_bad++; $display("FAIL ill_flags got %b want 0100", flags); end
        n_cmp++; if (wb_seen !== 0) begin n_bad++; $display("FAIL ill_no_wb got %0d want 0", wb_seen); end
        set_beat(4'hA, 32'h0, 4'b1111, 5'd0);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (illegal_cnt !== 8'd255 || flags !== 4'b0100) begin n_bad++; $display("FAIL ill_hold got %0d/%b want 255/0100", illegal_cnt, flags); end
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b0;
        set_beat(4'h0, 32'h0000_00AA, 4'b1111, 5'd10);
        tick();
        set_beat(4'h0, 32'h0000_00BB, 4'b1111, 5'd11);
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rm_skid_full got %b want 0", in_ready); end
        reset = 1'b1;
        tick();
        n_cmp++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rm_cleared got %b/%b want 0/1", wb_valid, in_ready); end
        n_cmp++; if (flags !== 4'b0000 || illegal_cnt !== 8'd0) begin n_bad++; $display("FAIL rm_state got %b/%0d want 0000/0", flags, illegal_cnt); end
        set_beat(4'h0, 32'h0000_00CC, 4'b1111, 5'd12);
        tick();
        n_cmp++; if (flags !== 4'b0000 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL rm_reset_wins got %b/%b want 0000/0", flags, wb_valid); end
        in_valid = 1'b0;
        reset = 1'b0;
        wb_ready = 1'b1;
        tick();
        n_cmp++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rm_after got %b/%b want 0/1", wb_valid, in_ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_partial_flags();
        test_cmp();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
